correlation_stim_seq: RTL and testbench

Synthesizable stimulus sequencer that sits directly upstream of the three-gate masked module under test. It walks every ordered pair of 5-bit input vectors {a, b, r1, r2, q}, giving 32 × 32 = 1024 transitions. For each pair it drives the "from" vector, then the "to" vector, holding each for a fixed number of cycles, and flags the transition instant so that the power/trace capture stage can align each simulation window. It can wait on the downstream capture before advancing, and can optionally refresh the mask bits from an LFSR.

---
 rtl/correlation_stim_seq_if.sv | 23 ++
 rtl/correlation_stim_seq.sv | 155 +++++++++++++++
 tb/tb_correlation_stim_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/correlation_stim_seq_if.sv
// Handshake/stimulus bundle between the correlation sequencer and its consumer (bench or capture).
interface correlation_stim_seq_if #(
  parameter int unsigned W = 5
);
  logic           start;
  logic           rdy;
  logic [W-1:0]   vec;
  logic           phase;
  logic           sim_begin;
  logic [2*W-1:0] sim_idx;
  logic           busy;
  logic           done;

  modport master (
    output start, rdy,
    input  vec, phase, sim_begin, sim_idx, busy, done
  );

  modport slave (
    input  start, rdy,
    output vec, phase, sim_begin, sim_idx, busy, done
  );
endinterface

// File: rtl/correlation_stim_seq.sv
// Walks all ordered pairs of W-bit vectors {a,b,r1,r2,q}, "from" then "to", flagging each transition.
// Optional CORR_MASK_LFSR_EN refreshes r1/r2 from a 16-bit LFSR on every phase entry.
module correlation_stim_seq #(
  parameter int unsigned W         = 5,
  parameter int unsigned HOLD      = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                   clk,
  input logic                   rst,
  correlation_stim_seq_if.slave stim_io
);

  typedef enum logic [2:0] {StIdle, StInit, StTrans, StWait, StDone} state_e;

  localparam logic [7:0]   HoldLast = 8'(HOLD - 1);
  localparam logic [W-1:0] VecOne   = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [W-1:0] i_q, j_q;
  logic [7:0]   h_q;
  logic [W-1:0] vec_q;
  logic         phase_q;
  logic         sim_begin_q;

  logic [W-1:0] i_nxt, j_nxt;
  logic         last_pair;
  logic         hold_end;

  always_comb begin
    j_nxt     = j_q + VecOne;
    i_nxt     = (&j_q) ? i_q + VecOne : i_q;
    last_pair = (&i_q) & (&j_q);
    hold_end  = (h_q == HoldLast);
  end

`ifdef CORR_MASK_LFSR_EN
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nxt;
  logic        phase_entry;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Mirrors the FSM's INIT/TRANS entry conditions
  always_comb begin
    phase_entry = 1'b0;
    unique case (state_q)
      StIdle, StDone: phase_entry = stim_io.start;
      StInit:         phase_entry = hold_end;
      StTrans:        phase_entry = hold_end & ~last_pair & stim_io.rdy;
      StWait:         phase_entry = stim_io.rdy;
      default:        phase_entry = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SeedEff;
    end else if (phase_entry) begin
      lfsr_q <= lfsr_nxt;
    end
  end

  // r1/r2 sit at bits [2:1]; requires W >= 3
  function automatic logic [W-1:0] mask_vec(input logic [W-1:0] v);
    mask_vec      = v;
    mask_vec[2:1] = lfsr_nxt[1:0];
  endfunction
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;

  function automatic logic [W-1:0] mask_vec(input logic [W-1:0] v);
    mask_vec = v;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      h_q         <= '0;
      vec_q       <= '0;
      phase_q     <= 1'b0;
      sim_begin_q <= 1'b0;
    end else begin
      sim_begin_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (stim_io.start) begin
            i_q     <= '0;
            j_q     <= '0;
            h_q     <= '0;
            vec_q   <= mask_vec('0);
            phase_q <= 1'b0;
            state_q <= StInit;
          end
        end
        StInit: begin
          if (hold_end) begin
            h_q         <= '0;
            vec_q       <= mask_vec(j_q);
            phase_q     <= 1'b1;
            sim_begin_q <= 1'b1;
            state_q     <= StTrans;
          end else begin
            h_q <= h_q + 8'd1;
          end
        end
        StTrans: begin
          if (hold_end) begin
            h_q <= '0;
            if (last_pair) begin
              // Counters stay at the final pair so sim_idx reads all-ones in DONE
              vec_q   <= '0;
              phase_q <= 1'b0;
              state_q <= StDone;
            end else if (stim_io.rdy) begin
              i_q     <= i_nxt;
              j_q     <= j_nxt;
              vec_q   <= mask_vec(i_nxt);
              phase_q <= 1'b0;
              state_q <= StInit;
            end else begin
              state_q <= StWait;
            end
          end else begin
            h_q <= h_q + 8'd1;
          end
        end
        StWait: begin
          if (stim_io.rdy) begin
            i_q     <= i_nxt;
            j_q     <= j_nxt;
            vec_q   <= mask_vec(i_nxt);
            phase_q <= 1'b0;
            state_q <= StInit;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stim_io.vec       = vec_q;
  assign stim_io.phase     = phase_q;
  assign stim_io.sim_begin = sim_begin_q;
  assign stim_io.sim_idx   = {i_q, j_q};
  assign stim_io.busy      = (state_q == StInit) || (state_q == StTrans) || (state_q == StWait);
  assign stim_io.done      = (state_q == StDone);

endmodule

// File: tb/tb_correlation_stim_seq.sv
// Directed bench for correlation_stim_seq: HOLD=2 instance for sequencing, HOLD=1 for the full sweep.
module tb_correlation_stim_seq;

  typedef struct packed {
    logic       start;
    logic       rdy;
    logic [4:0] vec;
    logic       phase;
    logic       sb;
    logic [9:0] idx;
    logic       busy;
    logic       done;
  } row_t;

`ifdef CORR_MASK_LFSR_EN
  localparam logic [18:0] OutMask = {5'b11001, 14'h3FFF};
`else
  localparam logic [18:0] OutMask = {19{1'b1}};
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  correlation_stim_seq_if #(.W(5)) bus2 ();
  correlation_stim_seq_if #(.W(5)) bus1 ();

  correlation_stim_seq #(.W(5), .HOLD(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .stim_io (bus2)
  );

  correlation_stim_seq #(.W(5), .HOLD(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .stim_io (bus1)
  );

  function automatic logic [18:0] out2();
    return {bus2.vec, bus2.phase, bus2.sim_begin, bus2.sim_idx, bus2.busy, bus2.done};
  endfunction

  function automatic logic [18:0] out1();
    return {bus1.vec, bus1.phase, bus1.sim_begin, bus1.sim_idx, bus1.busy, bus1.done};
  endfunction

  function automatic logic [18:0] ex(input int v, input int ph, input int sb, input int idx,
                                     input int bsy, input int dn);
    return {5'(v), 1'(ph), 1'(sb), 10'(idx), 1'(bsy), 1'(dn)};
  endfunction

  function automatic row_t row(input int st, input int rd, input int v, input int ph,
                               input int sb, input int idx, input int bsy, input int dn);
    row_t r;
    r.start = 1'(st);
    r.rdy   = 1'(rd);
    {r.vec, r.phase, r.sb, r.idx, r.busy, r.done} = ex(v, ph, sb, idx, bsy, dn);
    return r;
  endfunction

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if ((act & OutMask) === (exp & OutMask)) n_pass++;
    else $display("FAIL %s: got vec/ph/sb/idx/busy/done=%h required %h", name, act & OutMask,
                  exp & OutMask);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef CORR_MASK_LFSR_EN
  // Reference LFSR advanced on each observed INIT/TRANS entry of the HOLD=2 instance
  logic [15:0] lfsr_m;
  logic        prev_busy, prev_phase;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      lfsr_m     = 16'hACE1;
      prev_busy  = 1'b0;
      prev_phase = 1'b0;
    end else begin
      if (bus2.sim_begin || (bus2.busy && !bus2.phase && (!prev_busy || prev_phase))) begin
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        n_checks++;
        if (bus2.vec[2:1] === lfsr_m[1:0]) n_pass++;
        else $display("FAIL lfsr_mask: got r1r2=%b required %b", bus2.vec[2:1], lfsr_m[1:0]);
      end
      prev_busy  = bus2.busy;
      prev_phase = bus2.phase;
    end
  end
`endif

  row_t tbl [13];
  int   first_done;

  initial begin
    tbl[0]  = row(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(1, 1, 0, 0, 0, 0, 1, 0);
    tbl[2]  = row(0, 1, 0, 0, 0, 0, 1, 0);
    tbl[3]  = row(0, 1, 0, 1, 1, 0, 1, 0);
    tbl[4]  = row(0, 1, 0, 1, 0, 0, 1, 0);
    tbl[5]  = row(0, 1, 0, 0, 0, 1, 1, 0);
    tbl[6]  = row(0, 1, 0, 0, 0, 1, 1, 0);
    tbl[7]  = row(0, 1, 1, 1, 1, 1, 1, 0);
    tbl[8]  = row(0, 1, 1, 1, 0, 1, 1, 0);
    tbl[9]  = row(0, 1, 0, 0, 0, 2, 1, 0);
    tbl[10] = row(0, 1, 0, 0, 0, 2, 1, 0);
    tbl[11] = row(1, 1, 2, 1, 1, 2, 1, 0);  // start while busy must be ignored
    tbl[12] = row(0, 1, 2, 1, 0, 2, 1, 0);

    bus2.start = 1'b0;
    bus2.rdy   = 1'b1;
    bus1.start = 1'b0;
    bus1.rdy   = 1'b1;

    step();
    chk("reset_hold2", out2(), ex(0, 0, 0, 0, 0, 0));
    chk("reset_hold1", out1(), ex(0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("idle_no_start", out2(), ex(0, 0, 0, 0, 0, 0));
    end

    // Basic sequencing, HOLD=2
    for (int k = 0; k < 13; k++) begin
      bus2.start = tbl[k].start;
      bus2.rdy   = tbl[k].rdy;
      step();
      chk($sformatf("table_row%0d", k), out2(),
          {tbl[k].vec, tbl[k].phase, tbl[k].sb, tbl[k].idx, tbl[k].busy, tbl[k].done});
    end
    bus2.start = 1'b0;

    // Back-pressure at the end of pair 5
    for (int k = 0; k < 12; k++) step();
    chk("bp_trans5", out2(), ex(5, 1, 0, 5, 1, 0));
    bus2.rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_wait%0d", k), out2(), ex(5, 1, 0, 5, 1, 0));
    end
    bus2.rdy = 1'b1;
    step();
    chk("bp_init6", out2(), ex(0, 0, 0, 6, 1, 0));

    // Outer counter wrap into pair 32 (from=1, to=0)
    for (int k = 0; k < 104; k++) step();
    chk("wrap_from", out2(), ex(1, 0, 0, 32, 1, 0));
    step();
    step();
    chk("wrap_to", out2(), ex(0, 1, 1, 32, 1, 0));

    // Asynchronous reset in the TRANS of pair 100 (i=3, j=4)
    for (int k = 0; k < 272; k++) step();
    chk("trans100", out2(), ex(4, 1, 1, 100, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", out2(), ex(0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", out2(), ex(0, 0, 0, 0, 0, 0));
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    chk("restart_init", out2(), ex(0, 0, 0, 0, 1, 0));
    step();
    step();
    chk("restart_trans", out2(), ex(0, 1, 1, 0, 1, 0));

    // Full sweep, HOLD=1
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("sweep_first", out1(), ex(0, 0, 0, 0, 1, 0));
    first_done = 0;
    for (int n = 1; n <= 2100 && first_done == 0; n++) begin
      bus1.start = (n == 600);
      step();
      if (n == 601)  chk("sweep_pair300", out1(), ex(12, 1, 1, 300, 1, 0));
      if (n == 2046) chk("sweep_last_from", out1(), ex(31, 0, 0, 1023, 1, 0));
      if (n == 2047) chk("sweep_last_to", out1(), ex(31, 1, 1, 1023, 1, 0));
      if (bus1.done) first_done = n;
    end
    bus1.start = 1'b0;
    chk_int("sweep_length", first_done, 2048);
    chk("sweep_done", out1(), ex(0, 0, 0, 1023, 0, 1));
    step();
    chk("done_holds", out1(), ex(0, 0, 0, 1023, 0, 1));
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("done_restart", out1(), ex(0, 0, 0, 0, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
